// File: rtl/controle_memoria_pkg.sv
// Shared types and constants for the load/store memory controller.
// The tipo encoding matches the access size field driven by the CPU.
package controle_memoria_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ESCREVER = 3'd1,
        LER1     = 3'd2,
        LER2     = 3'd3,
        FIM      = 3'd4
    } estadoT;

    localparam logic [1:0] TIPO_PALAVRA = 2'b00;
    localparam logic [1:0] TIPO_BYTE    = 2'b01;
    localparam logic [1:0] TIPO_MEIA    = 2'b10;

    // Word is any encoding other than byte/halfword, so 2'b11 falls into the default.
    function automatic logic acessoDesalinhado(input logic [1:0] tipo,
                                               input logic [1:0] byteOfs);
        logic res;
        case (tipo)
            TIPO_BYTE: res = 1'b0;
            TIPO_MEIA: res = byteOfs[0];
            default:   res = (byteOfs != 2'b00);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/controle_memoria_extensor.sv
// Combinational load-data extension: picks the byte, halfword or word lane
// and sign- or zero-extends it to the full data width.
module extensor_sinal
    import controle_memoria_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] dado,
    input  logic [1:0]            tipo,
    input  logic                  sinal,
    output logic [DATA_WIDTH-1:0] resultado
);

    always_comb begin
        resultado = dado;
        case (tipo)
            TIPO_BYTE: resultado = {{(DATA_WIDTH-8){sinal & dado[7]}}, dado[7:0]};
            TIPO_MEIA: resultado = {{(DATA_WIDTH-16){sinal & dado[15]}}, dado[15:0]};
            default:   resultado = dado;
        endcase
    end

endmodule

// File: rtl/controle_memoria.sv
// CPU-side load/store controller driving a simple synchronous data memory.
// Define CONTROLE_MEMORIA_ALINHAMENTO_EN to reject misaligned halfword/word accesses.
module controle_memoria
    import controle_memoria_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            tipo,
    input  logic                  sinal,
    input  logic [ADDR_WIDTH+1:0] endereco,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] mem_saida,
    output logic                  ocupado,
    output logic                  pronto,
    output logic                  erro,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH+1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [1:0]            mem_DataType,
    output logic                  mem_EscMen,
    output logic                  mem_ReadMen
);

    estadoT                estadoAtual, proximoEstado;
    logic                  aceite;
    logic                  desalinhado;
    logic [ADDR_WIDTH+1:0] addrQ;
    logic [DATA_WIDTH-1:0] dataQ;
    logic [DATA_WIDTH-1:0] rdataQ;
    logic [DATA_WIDTH-1:0] extendido;
    logic [1:0]            tipoQ;
    logic                  sinalQ;

    assign aceite = (estadoAtual == OCIOSO) && req;

`ifdef CONTROLE_MEMORIA_ALINHAMENTO_EN
    logic erroQ;

    assign desalinhado = acessoDesalinhado(tipo, endereco[1:0]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            erroQ <= 1'b0;
        end else if (aceite) begin
            erroQ <= desalinhado;
        end
    end

    assign erro = pronto & erroQ;
`else
    assign desalinhado = 1'b0;
    assign erro        = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estadoAtual <= OCIOSO;
        end else begin
            estadoAtual <= proximoEstado;
        end
    end

    always_comb begin
        proximoEstado = estadoAtual;
        case (estadoAtual)
            OCIOSO: begin
                if (req) begin
                    // A rejected access still reports through FIM so the CPU sees pronto/erro.
                    if (desalinhado) begin
                        proximoEstado = FIM;
                    end else if (we) begin
                        proximoEstado = ESCREVER;
                    end else begin
                        proximoEstado = LER1;
                    end
                end
            end
            ESCREVER: proximoEstado = FIM;
            LER1:     proximoEstado = LER2;
            LER2:     proximoEstado = FIM;
            FIM:      proximoEstado = OCIOSO;
            default:  proximoEstado = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addrQ  <= '0;
            dataQ  <= '0;
            tipoQ  <= TIPO_PALAVRA;
            sinalQ <= 1'b0;
        end else if (aceite) begin
            addrQ  <= endereco;
            dataQ  <= wdata;
            tipoQ  <= tipo;
            sinalQ <= sinal;
        end
    end

    extensor_sinal #(
        .DATA_WIDTH(DATA_WIDTH)
    ) uExtensor (
        .dado      (mem_saida),
        .tipo      (tipoQ),
        .sinal     (sinalQ),
        .resultado (extendido)
    );

    // Memory data is valid during LER2; rdata holds until the next completed load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdataQ <= '0;
        end else if (estadoAtual == LER2) begin
            rdataQ <= extendido;
        end
    end

    always_comb begin
        ocupado     = (estadoAtual != OCIOSO);
        pronto      = (estadoAtual == FIM);
        mem_EscMen  = (estadoAtual == ESCREVER);
        mem_ReadMen = (estadoAtual == LER1) || (estadoAtual == LER2);
    end

    assign rdata        = rdataQ;
    assign mem_addr     = addrQ;
    assign mem_data     = dataQ;
    assign mem_DataType = tipoQ;

endmodule

// File: tb/tb_controle_memoria.sv
// Self-checking bench for controle_memoria: timeline-based reference model plus directed cases.
// Honours CONTROLE_MEMORIA_ALINHAMENTO_EN the same way the design does.
module tb_controle_memoria;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req, we, sinal;
    logic [1:0]  tipo;
    logic [5:0]  endereco;
    logic [31:0] wdata, mem_saida;
    logic        ocupado, pronto, erro, mem_EscMen, mem_ReadMen;
    logic [31:0] rdata, mem_data;
    logic [5:0]  mem_addr;
    logic [1:0]  mem_DataType;

    int total = 0;
    int bad   = 0;

    controle_memoria #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req          (req),
        .we           (we),
        .tipo         (tipo),
        .sinal        (sinal),
        .endereco     (endereco),
        .wdata        (wdata),
        .mem_saida    (mem_saida),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .erro         (erro),
        .rdata        (rdata),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_DataType (mem_DataType),
        .mem_EscMen   (mem_EscMen),
        .mem_ReadMen  (mem_ReadMen)
    );

    always #5 clock = ~clock;

    // Model: an accepted access lives for mLat cycles after acceptance (age 1..mLat),
    // completing in its last cycle; age 0 means idle.
    int          mAge, mLat;
    bit          mStore, mErr;
    logic [5:0]  mAddr;
    logic [31:0] mData, mRdata;
    logic [1:0]  mTipo;
    bit          mSinal;

    logic        obsPronto, obsErro, obsEsc;
    logic [31:0] obsRdata;
    logic [5:0]  obsAddr;

    task automatic modelReset();
        mAge = 0; mLat = 0; mStore = 0; mErr = 0;
        mAddr = '0; mData = '0; mTipo = 2'b00; mSinal = 0; mRdata = '0;
    endtask

    function automatic logic [31:0] modelExt(input logic [31:0] v, input logic [1:0] t, input bit s);
        logic [31:0] r;
        if (t == 2'b01) begin
            r = v % 256;
            if (s && r >= 128) r = r + 32'hFFFFFF00;
        end else if (t == 2'b10) begin
            r = v % 65536;
            if (s && r >= 32768) r = r + 32'hFFFF0000;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic bit modelMisaligned(input logic [1:0] t, input logic [5:0] a);
`ifdef CONTROLE_MEMORIA_ALINHAMENTO_EN
        if (t == 2'b01) return 0;
        if (t == 2'b10) return (a % 2) != 0;
        return (a % 4) != 0;
`else
        return 0;
`endif
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutputs();
        bit done;
        done = (mAge != 0) && (mAge == mLat);
        cmp("ocupado", {31'b0, ocupado}, {31'b0, mAge != 0});
        cmp("pronto", {31'b0, pronto}, {31'b0, done});
        cmp("erro", {31'b0, erro}, {31'b0, done && mErr});
        cmp("mem_EscMen", {31'b0, mem_EscMen}, {31'b0, mAge == 1 && mStore && !mErr});
        cmp("mem_ReadMen", {31'b0, mem_ReadMen},
            {31'b0, !mStore && !mErr && (mAge == 1 || mAge == 2)});
        cmp("rdata", rdata, mRdata);
        cmp("mem_addr", {26'b0, mem_addr}, {26'b0, mAddr});
        cmp("mem_data", mem_data, mData);
        cmp("mem_DataType", {30'b0, mem_DataType}, {30'b0, mTipo});
    endtask

    task automatic modelStep();
        if (mAge == 0) begin
            if (req) begin
                mAddr = endereco; mData = wdata; mTipo = tipo; mSinal = sinal;
                mStore = we;
                mErr = modelMisaligned(tipo, endereco);
                mLat = mErr ? 1 : (we ? 2 : 3);
                mAge = 1;
            end
        end else if (mAge == mLat) begin
            mAge = 0;
        end else begin
            if (!mStore && !mErr && mAge == 2) mRdata = modelExt(mem_saida, mTipo, mSinal);
            mAge++;
        end
    endtask

    task automatic cycle(input logic r, input logic w, input logic [1:0] t, input logic s,
                         input logic [5:0] a, input logic [31:0] wd, input logic [31:0] ms);
        @(posedge clock);
        #1;
        req = r; we = w; tipo = t; sinal = s; endereco = a; wdata = wd; mem_saida = ms;
        @(negedge clock);
        obsPronto = pronto; obsErro = erro; obsEsc = mem_EscMen;
        obsRdata = rdata; obsAddr = mem_addr;
        checkOutputs();
        modelStep();
    endtask

    // One-cycle req, then idle until pronto; returns latency in cycles from the req cycle.
    task automatic access(input logic w, input logic [1:0] t, input logic s, input logic [5:0] a,
                          input logic [31:0] wd, input logic [31:0] ms, output int lat,
                          output logic [31:0] rd, output logic er, output int escCnt,
                          output logic [5:0] escAddr);
        lat = -1; rd = 'x; er = 1'bx; escCnt = 0; escAddr = 'x;
        cycle(1'b1, w, t, s, a, wd, ms);
        for (int n = 1; n <= 10; n++) begin
            cycle(1'b0, w, t, s, a, wd, ms);
            if (obsEsc) begin
                escCnt++;
                escAddr = obsAddr;
            end
            if (obsPronto) begin
                lat = n; rd = obsRdata; er = obsErro;
                break;
            end
        end
        if (lat < 0) cmp("access_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int          lat, escCnt, prontoCnt;
        logic [31:0] rd;
        logic        er;
        logic [5:0]  ea;

        reset_n = 1'b0;
        req = 0; we = 0; tipo = 0; sinal = 0; endereco = 0; wdata = 0; mem_saida = 0;
        modelReset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutputs();
        reset_n = 1'b1;

        // Store word 0xDEADBEEF at 0x08
        access(1'b1, 2'b00, 1'b0, 6'h08, 32'hDEADBEEF, 32'h0, lat, rd, er, escCnt, ea);
        cmp("store_latency", lat, 32'd2);
        cmp("store_esc_cycles", escCnt, 32'd1);
        cmp("store_esc_addr", {26'b0, ea}, 32'h08);
        cmp("store_erro", {31'b0, er}, 32'd0);

        access(1'b0, 2'b01, 1'b1, 6'h08, 32'h0, 32'h000000EF, lat, rd, er, escCnt, ea);
        cmp("lb_signed", rd, 32'hFFFFFFEF);
        cmp("lb_latency", lat, 32'd3);
        access(1'b0, 2'b01, 1'b0, 6'h08, 32'h0, 32'h000000EF, lat, rd, er, escCnt, ea);
        cmp("lb_unsigned", rd, 32'h000000EF);
        access(1'b0, 2'b10, 1'b1, 6'h08, 32'h0, 32'h12348001, lat, rd, er, escCnt, ea);
        cmp("lh_signed", rd, 32'hFFFF8001);
        access(1'b0, 2'b10, 1'b0, 6'h0A, 32'h0, 32'h12348001, lat, rd, er, escCnt, ea);
        cmp("lh_unsigned", rd, 32'h00008001);

        access(1'b0, 2'b00, 1'b0, 6'h09, 32'h0, 32'hCAFEF00D, lat, rd, er, escCnt, ea);
`ifdef CONTROLE_MEMORIA_ALINHAMENTO_EN
        cmp("misaligned_latency", lat, 32'd1);
        cmp("misaligned_erro", {31'b0, er}, 32'd1);
        cmp("misaligned_rdata_kept", rd, 32'h00008001);
`else
        cmp("unaligned_latency", lat, 32'd3);
        cmp("unaligned_erro", {31'b0, er}, 32'd0);
        cmp("unaligned_rdata", rd, 32'hCAFEF00D);
`endif

        // req held high: one load accepted every 4th cycle
        prontoCnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, 2'b00, 1'b0, 6'h04, 32'h0, 32'h11110000 + i);
            if (obsPronto) prontoCnt++;
        end
        cmp("held_req_pronto_count", prontoCnt, 32'd3);
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 6'h04, 32'h0, 32'h0);

        // Reset during LER2 aborts the load at once
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 6'h0C, 32'h0, 32'h55AA55AA);
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 6'h0C, 32'h0, 32'h55AA55AA);
        @(posedge clock);
        #1;
        cmp("ler2_readmen", {31'b0, mem_ReadMen}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        cmp("reset_ocupado", {31'b0, ocupado}, 32'd0);
        cmp("reset_readmen", {31'b0, mem_ReadMen}, 32'd0);
        cmp("reset_pronto", {31'b0, pronto}, 32'd0);
        modelReset();
        @(negedge clock);
        checkOutputs();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        prontoCnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 2'b00, 1'b0, 6'h0, 32'h0, 32'h0);
            if (obsPronto) prontoCnt++;
        end
        cmp("no_pronto_after_reset", prontoCnt, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
